// File: rtl/spi_adapter_pkg.sv
// Shared definitions for the SPI minion adapter.
//   spi_state_e  : frame FSM states (IDLE, SHIFT, DONE)
//   pkt_bits()   : SPI packet length for a given payload width ({val, spc, data})
//   SYNC_STAGES  : number of synchroniser flops on each pad input
package spi_adapter_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    function automatic int pkt_bits(input int nbits);
        return nbits + 2;
    endfunction

endpackage

// File: rtl/spi_adapter_queue.sv
// Circular FIFO with val/rdy on both sides.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   enq_val/rdy/msg    : producer side
//   deq_val/rdy/msg    : consumer side (deq_msg is the head entry)
//   count              : current number of stored entries
// Handshake: a transfer happens on a rising clk edge where val and rdy are
// both high; val must not depend on rdy. A full queue still accepts an
// enqueue in the same cycle as a dequeue.
module spi_adapter_queue #(
    parameter int NBITS    = 32,
    parameter int NENTRIES = 5
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enq_val,
    output logic                            enq_rdy,
    input  logic [NBITS-1:0]                enq_msg,
    output logic                            deq_val,
    input  logic                            deq_rdy,
    output logic [NBITS-1:0]                deq_msg,
    output logic [$clog2(NENTRIES+1)-1:0]   count
);

    localparam int AW = $clog2(NENTRIES);
    localparam int CW = $clog2(NENTRIES + 1);
    localparam logic [AW-1:0] LAST = AW'(NENTRIES - 1);

    logic [NBITS-1:0] mem [NENTRIES];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             enq_fire;
    logic             deq_fire;

    assign deq_val  = (count != '0);
    assign deq_msg  = mem[rd_ptr];
    assign enq_rdy  = (count != CW'(NENTRIES)) || deq_rdy;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
            end
            if (deq_fire) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= enq_msg;
        end
    end

endmodule

// File: rtl/spi_minion_adapter_gen2.sv
// SPI minion with val/rdy receive and transmit queues toward the core.
// Optional feature macro: SPI_ERR_CNT_EN (adds err_count output).
// Ports:
//   clk, reset                 : system clock, synchronous active-high reset
//   spi_min_cs/sclk/mosi/miso  : SPI pads (cs active low, mode CPOL=0)
//   loopthrough_sel            : route received data straight to transmit queue
//   recv_msg/val/rdy           : receive queue head toward the core
//   send_msg/val/rdy           : core data into the transmit queue
//   minion_parity              : XOR of last data pushed to receive queue
//   adapter_parity             : XOR of last data popped from transmit queue
//   err_count (SPI_ERR_CNT_EN) : saturating count of aborted/dropped frames
// Handshake: every val/rdy pair transfers on a rising clk edge with both high;
// val never depends on rdy of the same interface.
// Packet (MSB first, NBITS+2 bits): {val, spc, data[NBITS-1:0]}.
// Debug: the frame FSM state is held in state_q.
module spi_minion_adapter_gen2
    import spi_adapter_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int NENTRIES     = 5,
    parameter bit CPHA_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_min_cs,
    input  logic             spi_min_sclk,
    input  logic             spi_min_mosi,
    output logic             spi_min_miso,
    input  logic             loopthrough_sel,
    output logic [NBITS-1:0] recv_msg,
    output logic             recv_val,
    input  logic             recv_rdy,
    input  logic [NBITS-1:0] send_msg,
    input  logic             send_val,
    output logic             send_rdy,
    output logic             minion_parity,
    output logic             adapter_parity
`ifdef SPI_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    localparam int P   = pkt_bits(NBITS);
    localparam int CW  = $clog2(P + 2);
    localparam int QCW = $clog2(NENTRIES + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(P);
    localparam logic [CW-1:0] CNT_MAX  = CW'(P + 1);

    // Index SYNC_STAGES-1 is the last synchroniser flop; index SYNC_STAGES
    // is the extra flop used only for edge detection.
    logic [SYNC_STAGES:0]   cs_pipe;
    logic [SYNC_STAGES:0]   sclk_pipe;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_now;
    logic sample_edge, shift_edge;

    spi_state_e       state_q, state_d;
    logic [P-1:0]     tx_sr;
    logic [P-1:0]     rx_sr;
    logic [CW-1:0]    bit_cnt;
    logic             cap_tx_val;
    logic             cap_rx_spc;
    logic             cpha_q;
    logic             loop_q;

    logic             frame_ok, rx_push, tx_pop, rx_drop;
    logic             tx_has_data, rx_has_space;
    logic [NBITS-1:0] tx_head;

    logic             rx_enq_rdy, rx_deq_val, rx_deq_rdy;
    logic [NBITS-1:0] rx_deq_msg;
    logic [QCW-1:0]   rx_count;
    logic             tx_enq_val, tx_enq_rdy, tx_deq_val;
    logic [NBITS-1:0] tx_enq_msg, tx_deq_msg;
    logic [QCW-1:0]   tx_count;

    // cs synchronisers reset to 0 (asserted) so a cs that is already low at
    // reset release never looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_pipe   <= '0;
            sclk_pipe <= '0;
            mosi_pipe <= '0;
        end else begin
            cs_pipe   <= {cs_pipe[SYNC_STAGES-1:0], spi_min_cs};
            sclk_pipe <= {sclk_pipe[SYNC_STAGES-1:0], spi_min_sclk};
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_min_mosi};
        end
    end

    assign cs_rise     =  cs_pipe[SYNC_STAGES-1]   && !cs_pipe[SYNC_STAGES];
    assign cs_fall     = !cs_pipe[SYNC_STAGES-1]   &&  cs_pipe[SYNC_STAGES];
    assign sclk_rise   =  sclk_pipe[SYNC_STAGES-1] && !sclk_pipe[SYNC_STAGES];
    assign sclk_fall   = !sclk_pipe[SYNC_STAGES-1] &&  sclk_pipe[SYNC_STAGES];
    assign mosi_now    = mosi_pipe[SYNC_STAGES-1];
    assign sample_edge = cpha_q ? sclk_fall : sclk_rise;
    assign shift_edge  = cpha_q ? sclk_rise : sclk_fall;

    assign tx_has_data  = (tx_count != '0);
    assign rx_has_space = (rx_count < QCW'(NENTRIES));
    assign tx_head      = tx_has_data ? tx_deq_msg : '0;

    // Frame FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift datapath. The tx register is not shifted until the first bit has
    // been sampled: in CPHA=1 the leading edge is a shift edge and must not
    // discard the MSB that was presented at cs fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            cap_tx_val <= 1'b0;
            cap_rx_spc <= 1'b0;
            cpha_q     <= CPHA_DEFAULT;
            loop_q     <= 1'b0;
        end else begin
            cpha_q <= cpha_q;
            case (state_q)
                IDLE: begin
                    loop_q <= loopthrough_sel;
                    if (cs_fall) begin
                        tx_sr      <= {tx_has_data, rx_has_space, tx_head};
                        rx_sr      <= '0;
                        bit_cnt    <= '0;
                        cap_tx_val <= tx_has_data;
                        cap_rx_spc <= rx_has_space;
                    end
                end
                SHIFT: begin
                    if (sample_edge) begin
                        rx_sr <= {rx_sr[P-2:0], mosi_now};
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    if (shift_edge && (bit_cnt != '0)) begin
                        tx_sr <= {tx_sr[P-2:0], 1'b0};
                    end
                end
                DONE: begin
                    tx_sr   <= '0;
                    rx_sr   <= '0;
                    bit_cnt <= '0;
                end
                default: begin
                    tx_sr <= '0;
                end
            endcase
        end
    end

    // Frame completion decisions, only meaningful in DONE with an exact count
    assign frame_ok = (state_q == DONE) && (bit_cnt == CNT_FULL);
    assign rx_push  = frame_ok && rx_sr[P-1] && cap_rx_spc && rx_enq_rdy;
    assign rx_drop  = frame_ok && rx_sr[P-1] && !cap_rx_spc;
    assign tx_pop   = frame_ok && cap_tx_val && rx_sr[P-2] && tx_deq_val;

    assign spi_min_miso = !reset && !cs_pipe[SYNC_STAGES-1] && tx_sr[P-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            minion_parity  <= 1'b0;
            adapter_parity <= 1'b0;
        end else begin
            if (rx_push) minion_parity  <= ^rx_sr[NBITS-1:0];
            if (tx_pop)  adapter_parity <= ^tx_deq_msg;
        end
    end

`ifdef SPI_ERR_CNT_EN
    logic frame_abort;
    assign frame_abort = (state_q == DONE) && (bit_cnt != CNT_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if ((frame_abort || rx_drop) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`else
    // Drops are silent in this build; the term is kept only to keep the
    // frame decision logic in one place.
    logic unused_drop;
    assign unused_drop = rx_drop;
`endif

    // Core / loopthrough routing
    assign rx_deq_rdy = loop_q ? tx_enq_rdy : recv_rdy;
    assign tx_enq_val = loop_q ? rx_deq_val : send_val;
    assign tx_enq_msg = loop_q ? rx_deq_msg : send_msg;
    assign recv_msg   = rx_deq_msg;
    assign recv_val   = !reset && !loop_q && rx_deq_val;
    assign send_rdy   = !reset && !loop_q && tx_enq_rdy;

    spi_adapter_queue #(.NBITS(NBITS), .NENTRIES(NENTRIES)) u_rx_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (rx_push),
        .enq_rdy (rx_enq_rdy),
        .enq_msg (rx_sr[NBITS-1:0]),
        .deq_val (rx_deq_val),
        .deq_rdy (rx_deq_rdy),
        .deq_msg (rx_deq_msg),
        .count   (rx_count)
    );

    spi_adapter_queue #(.NBITS(NBITS), .NENTRIES(NENTRIES)) u_tx_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (tx_enq_val),
        .enq_rdy (tx_enq_rdy),
        .enq_msg (tx_enq_msg),
        .deq_val (tx_deq_val),
        .deq_rdy (tx_pop),
        .deq_msg (tx_deq_msg),
        .count   (tx_count)
    );

endmodule

// File: tb/tb_spi_minion_adapter_gen2.sv
// Testbench for spi_minion_adapter_gen2 (default parameters, CPHA=0).
// Received words are checked by a monitor against an expected queue filled
// by a reference model of the packet rules; miso packets and parities are
// checked per frame against the same model.
module tb_spi_minion_adapter_gen2;
    import spi_adapter_pkg::*;

    localparam int NB = 32;
    localparam int NE = 5;
    localparam int P  = NB + 2;
    localparam int H  = 40;

    logic          clk;
    logic          reset;
    logic          spi_cs, spi_sclk, spi_mosi;
    logic          spi_miso;
    logic          loop_sel;
    logic [NB-1:0] recv_msg;
    logic          recv_val, recv_rdy;
    logic [NB-1:0] send_msg;
    logic          send_val, send_rdy;
    logic          minion_parity, adapter_parity;
`ifdef SPI_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    spi_minion_adapter_gen2 #(.NBITS(NB), .NENTRIES(NE), .CPHA_DEFAULT(1'b0)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi_min_cs      (spi_cs),
        .spi_min_sclk    (spi_sclk),
        .spi_min_mosi    (spi_mosi),
        .spi_min_miso    (spi_miso),
        .loopthrough_sel (loop_sel),
        .recv_msg        (recv_msg),
        .recv_val        (recv_val),
        .recv_rdy        (recv_rdy),
        .send_msg        (send_msg),
        .send_val        (send_val),
        .send_rdy        (send_rdy),
        .minion_parity   (minion_parity),
        .adapter_parity  (adapter_parity)
`ifdef SPI_ERR_CNT_EN
        ,
        .err_count       (err_count)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard / model state ----------------
    int            n_checks = 0;
    int            n_err    = 0;
    logic [NB-1:0] exp_q[$];
    logic [NB-1:0] m_tx[$];
    int            m_rx_cnt  = 0;
    logic          m_rdy     = 1'b0;
    logic          m_loop    = 1'b0;
    logic          m_min_par = 1'b0;
    logic          m_adp_par = 1'b0;
    int            m_err     = 0;
    logic [NB-1:0] mon_exp;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every core-side receive handshake is compared in order.
    always @(negedge clk) begin
        if (!reset && recv_val && recv_rdy) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL recv_unexpected got=%0h exp=none", recv_msg);
            end else begin
                mon_exp = exp_q.pop_front();
                if (recv_msg !== mon_exp) begin
                    n_err++;
                    $display("FAIL recv_msg got=%0h exp=%0h", recv_msg, mon_exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic settle();
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic set_rdy(input logic v);
        @(posedge clk);
        #1;
        recv_rdy = v;
        m_rdy    = v;
        if (v) begin
            repeat (NE + 4) @(posedge clk);
            #1;
            m_rx_cnt = 0;
        end
    endtask

    task automatic core_send(input logic [NB-1:0] d);
        int k;
        @(posedge clk);
        #1;
        send_val = 1'b1;
        send_msg = d;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (send_rdy) break;
        end
        if (k == 50) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout got=0 exp=1");
        end else begin
            m_tx.push_back(d);
        end
        @(posedge clk);
        #1;
        send_val = 1'b0;
    endtask

    // Mode 0 master: mosi changes on falling sclk, miso sampled before rising.
    // rst_at >= 0 pulses reset for one cycle during that bit's low phase.
    task automatic run_frame(input logic [P-1:0] pkt, input int nbit, input int rst_at,
                             output logic [P-1:0] got);
        logic [P-1:0] sh;
        got = '0;
        sh  = pkt;
        @(posedge clk);
        #1;
        spi_cs   = 1'b0;
        spi_mosi = sh[P-1];
        #(H);
        for (int i = 0; i < nbit; i++) begin
            got[P-1-i] = spi_miso;
            spi_sclk = 1'b1;
            #(H);
            spi_sclk = 1'b0;
            sh       = sh << 1;
            spi_mosi = sh[P-1];
            if (i == rst_at) begin
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end
            #(H);
        end
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
    endtask

    // Full-length frame with model prediction of miso, queue effects and parity.
    task automatic full_frame(input logic [P-1:0] pkt, input bit lat_chk);
        logic [P-1:0] exp_miso, got;
        logic         tv, rs;
        int           lat;
        tv = (m_tx.size() != 0);
        rs = (m_rx_cnt < NE);
        exp_miso = {tv, rs, (tv ? m_tx[0] : {NB{1'b0}})};
        if (pkt[P-1] && rs) begin
            m_min_par = ^pkt[NB-1:0];
            if (m_loop) begin
                m_tx.push_back(pkt[NB-1:0]);
            end else begin
                exp_q.push_back(pkt[NB-1:0]);
                if (!m_rdy) m_rx_cnt++;
            end
        end else if (pkt[P-1]) begin
            m_err++;
        end
        if (tv && pkt[P-2]) begin
            m_adp_par = ^m_tx[0];
            void'(m_tx.pop_front());
        end
        run_frame(pkt, P, -1, got);
        if (lat_chk) begin
            for (lat = 1; lat <= 20; lat++) begin
                @(posedge clk);
                #1;
                if (recv_val) break;
            end
            check("recv_latency", lat, 4);
            check("recv_msg_head", recv_msg, pkt[NB-1:0]);
        end
        check("miso_packet", got, exp_miso);
        settle();
        check("minion_parity", minion_parity, m_min_par);
        check("adapter_parity", adapter_parity, m_adp_par);
        if (m_loop) check("loop_recv_val", recv_val, 1'b0);
    endtask

    function automatic logic [P-1:0] mk_pkt(input logic v, input logic s, input logic [NB-1:0] d);
        return {v, s, d};
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #(3_000_000);
        n_err++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [P-1:0]  got;
        logic [NB-1:0] w;
        reset    = 1'b1;
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        loop_sel = 1'b0;
        recv_rdy = 1'b0;
        send_msg = '0;
        send_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_miso", spi_miso, 1'b0);
        check("rst_recv_val", recv_val, 1'b0);
        check("rst_send_rdy", send_rdy, 1'b0);
        check("rst_minion_parity", minion_parity, 1'b0);
        check("rst_adapter_parity", adapter_parity, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_state", dut.state_q, IDLE);
        check("post_rst_send_rdy", send_rdy, 1'b1);
        check("post_rst_recv_val", recv_val, 1'b0);

        // 1: frame into empty queues, latency and miso {0,1,0...}
        full_frame(mk_pkt(1'b1, 1'b1, 32'hDEADBEEF), 1'b1);
        set_rdy(1'b1);

        // 2: core word returned on miso and popped by spc=1
        core_send(32'h0000_0001);
        full_frame(mk_pkt(1'b0, 1'b1, 32'h0), 1'b0);
        check("send_rdy_after_pop", send_rdy, 1'b1);

        // 3: fill receive queue, sixth frame dropped
        set_rdy(1'b0);
        for (int f = 0; f < NE + 1; f++) begin
            full_frame(mk_pkt(1'b1, 1'b1, $urandom), 1'b0);
        end
`ifdef SPI_ERR_CNT_EN
        check("err_count_drop", err_count, m_err);
`endif
        set_rdy(1'b1);

        // 4: short frame aborts, then a normal frame
        core_send($urandom);
        run_frame(mk_pkt(1'b1, 1'b1, $urandom), 10, -1, got);
        m_err++;
        settle();
        check("abort_state", dut.state_q, IDLE);
        check("abort_recv_val", recv_val, 1'b0);
        full_frame(mk_pkt(1'b1, 1'b1, 32'h12345678), 1'b0);

        // 5: loopthrough
        @(posedge clk);
        #1 loop_sel = 1'b1;
        m_loop = 1'b1;
        full_frame(mk_pkt(1'b1, 1'b1, 32'hA5A5A5A5), 1'b0);
        full_frame(mk_pkt(1'b0, 1'b1, 32'h0), 1'b0);
        @(posedge clk);
        #1 loop_sel = 1'b0;
        m_loop = 1'b0;

        // 6: reset during a frame clears everything
        core_send($urandom);
        run_frame(mk_pkt(1'b1, 1'b1, $urandom), P, 10, got);
        m_tx.delete();
        exp_q.delete();
        m_rx_cnt  = 0;
        m_min_par = 1'b0;
        m_adp_par = 1'b0;
        m_err     = 0;
        settle();
        check("rstmid_state", dut.state_q, IDLE);
        check("rstmid_recv_val", recv_val, 1'b0);
        check("rstmid_minion_parity", minion_parity, 1'b0);
        check("rstmid_adapter_parity", adapter_parity, 1'b0);
        full_frame(mk_pkt(1'b1, 1'b1, $urandom), 1'b0);

        // 7: randomized frames with random core traffic
        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 3) == 0) set_rdy(1'b0);
            else if (!m_rdy) set_rdy(1'b1);
            if ((m_tx.size() < NE) && ($urandom_range(0, 1) == 1)) begin
                w = $urandom;
                core_send(w);
            end
            full_frame(mk_pkt($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom), 1'b0);
        end

        set_rdy(1'b1);
        settle();
        check("exp_q_drained", exp_q.size(), 0);
`ifdef SPI_ERR_CNT_EN
        check("err_count_final", err_count, (m_err > 255) ? 255 : m_err);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
